// File: rtl/dbg_uart_word_seq_if.sv
// Word/byte handshake bundle between the debug tap UART and the
// debug command FSM, as seen by the word sequencer.
interface dbg_uart_word_seq_if;
    logic        flush_i;
    logic [7:0]  rx_byte_i;
    logic        rx_valid_i;
    logic [31:0] rx_word_o;
    logic        rx_word_valid_o;
    logic        rx_word_ready_i;
    logic [31:0] tx_word_i;
    logic        tx_word_valid_i;
    logic        tx_word_ready_o;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_done_i;
    logic        rx_timeout_o;
    logic        rx_overrun_o;

    modport slave (
        input  flush_i, rx_byte_i, rx_valid_i, rx_word_ready_i,
        input  tx_word_i, tx_word_valid_i, tx_done_i,
        output rx_word_o, rx_word_valid_o, tx_word_ready_o,
        output tx_byte_o, tx_valid_o, rx_timeout_o, rx_overrun_o
    );

    modport master (
        output flush_i, rx_byte_i, rx_valid_i, rx_word_ready_i,
        output tx_word_i, tx_word_valid_i, tx_done_i,
        input  rx_word_o, rx_word_valid_o, tx_word_ready_o,
        input  tx_byte_o, tx_valid_o, rx_timeout_o, rx_overrun_o
    );
endinterface

// File: rtl/dbg_uart_word_seq.sv
// Packs UART RX bytes into 32-bit debug words and serialises
// 32-bit debug words back out as four UART TX bytes.
module dbg_uart_word_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 34720,
    parameter bit          BIG_ENDIAN     = 1'b0
) (
    input logic                clk,
    input logic                rstn_i,
    dbg_uart_word_seq_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]    rx_cnt_q;
    logic [TW-1:0] rx_tmr_q;
    logic [TW-1:0] rx_tmr_inc;
    logic [31:0]   rx_asm_q;
    logic [31:0]   rx_asm_nxt;
    logic [31:0]   rx_word_q;
    logic          rx_vld_q;
    logic          rx_to_q;
    logic          rx_ovr_q;
    logic [1:0]    rx_lane;
    logic          rx_acc;
    logic          rx_last;
    logic          rx_tmr_hit;

    assign rx_lane = BIG_ENDIAN ? 2'd3 - rx_cnt_q : rx_cnt_q;

    always_comb begin
        rx_asm_nxt = rx_asm_q;
        rx_asm_nxt[{rx_lane, 3'b000} +: 8] = bus.rx_byte_i;
    end

    assign rx_acc  = rx_vld_q & bus.rx_word_ready_i;
    assign rx_last = bus.rx_valid_i & (rx_cnt_q == 2'd3);

    // Saturating increment; the timer is cleared on hit anyway
    assign rx_tmr_inc = (rx_tmr_q == TMAX) ? rx_tmr_q
                                           : rx_tmr_q + 1'b1;
    assign rx_tmr_hit = (rx_cnt_q != 2'd0) && !bus.rx_valid_i &&
                        (rx_tmr_inc == TMAX);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_cnt_q  <= '0;
            rx_tmr_q  <= '0;
            rx_asm_q  <= '0;
            rx_word_q <= '0;
            rx_vld_q  <= 1'b0;
            rx_to_q   <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else if (bus.flush_i) begin
            rx_cnt_q  <= '0;
            rx_tmr_q  <= '0;
            rx_asm_q  <= '0;
            rx_word_q <= '0;
            rx_vld_q  <= 1'b0;
            rx_to_q   <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else begin
            if (rx_acc) begin
                rx_vld_q <= 1'b0;
            end
            if (bus.rx_valid_i) begin
                rx_cnt_q <= rx_cnt_q + 2'd1;
                rx_tmr_q <= '0;
                rx_asm_q <= rx_last ? '0 : rx_asm_nxt;
                if (rx_last) begin
                    if (!rx_vld_q || rx_acc) begin
                        rx_word_q <= rx_asm_nxt;
                        rx_vld_q  <= 1'b1;
                    end else begin
                        rx_ovr_q <= 1'b1;
                    end
                end
            end else if (rx_cnt_q != 2'd0) begin
                if (rx_tmr_hit) begin
                    rx_cnt_q <= '0;
                    rx_tmr_q <= '0;
                    rx_asm_q <= '0;
                    rx_to_q  <= 1'b1;
                end else begin
                    rx_tmr_q <= rx_tmr_inc;
                end
            end
        end
    end

    assign bus.rx_word_o       = rx_word_q;
    assign bus.rx_word_valid_o = rx_vld_q;
    assign bus.rx_timeout_o    = rx_to_q;
    assign bus.rx_overrun_o    = rx_ovr_q;

    typedef enum logic {
        T_IDLE,
        T_SEND
    } tx_state_e;

    tx_state_e   st_q;
    tx_state_e   st_d;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [31:0] txw_q;
    logic [31:0] txw_d;
    logic [1:0]  tx_lane;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            st_q  <= T_IDLE;
            idx_q <= '0;
            txw_q <= '0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            txw_q <= txw_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        txw_d = txw_q;
        unique case (st_q)
            T_IDLE: begin
                if (bus.tx_word_valid_i) begin
                    st_d  = T_SEND;
                    idx_d = 2'd0;
                    txw_d = bus.tx_word_i;
                end
            end
            T_SEND: begin
                if (bus.tx_done_i) begin
                    if (idx_q == 2'd3) begin
                        st_d = T_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
        endcase
        // Abandon any byte in flight
        if (bus.flush_i) begin
            st_d  = T_IDLE;
            idx_d = 2'd0;
            txw_d = '0;
        end
    end

    assign tx_lane = BIG_ENDIAN ? 2'd3 - idx_q : idx_q;

    assign bus.tx_word_ready_o = (st_q == T_IDLE);
    assign bus.tx_valid_o      = (st_q == T_SEND);
    assign bus.tx_byte_o       = (st_q == T_SEND) ?
                                 txw_q[{tx_lane, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_dbg_uart_word_seq.sv
// Self-checking bench for dbg_uart_word_seq (TIMEOUT_CYCLES=16,
// little-endian lanes), scoreboarded RX words and TX bytes.
module tb_dbg_uart_word_seq;
    localparam int TO = 16;

    logic clk    = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    dbg_uart_word_seq_if bus();

    dbg_uart_word_seq #(
        .TIMEOUT_CYCLES(TO),
        .BIG_ENDIAN    (1'b0)
    ) dut (
        .clk   (clk),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rx_q[$];
    logic [7:0]  tx_q[$];

    logic resp_en   = 1'b0;
    logic resp_done = 1'b0;
    logic man_done  = 1'b0;
    logic prev_done = 1'b0;
    int   resp_dly  = 0;
    int   tx_dones  = 0;

    assign bus.tx_done_i = resp_done | man_done;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } rx_vec_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  e0, e1, e2, e3;
    } tx_vec_t;

    rx_vec_t rx_vecs[5];
    tx_vec_t tx_vecs[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.rx_byte_i  = b;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic rx_word(input rx_vec_t v);
        rx_q.push_back(v.exp);
        rx_byte(v.b0);
        rx_byte(v.b1);
        rx_byte(v.b2);
        rx_byte(v.b3);
    endtask

    task automatic wait_tx_idle(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || !bus.tx_word_ready_o) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: tx stuck, ready %0b pending %0d",
                     name, bus.tx_word_ready_o, tx_q.size());
        end else begin
            chk({name, "_valid_low"}, {31'd0, bus.tx_valid_o}, 32'd0);
        end
    endtask

    task automatic tx_send(input tx_vec_t v);
        int n;
        n = 0;
        while (!bus.tx_word_ready_o && n < 200) begin
            tick();
            n++;
        end
        chk("tx_ready_before", {31'd0, bus.tx_word_ready_o}, 32'd1);
        tx_q.push_back(v.e0);
        tx_q.push_back(v.e1);
        tx_q.push_back(v.e2);
        tx_q.push_back(v.e3);
        bus.tx_word_i       = v.word;
        bus.tx_word_valid_i = 1'b1;
        tick();
        bus.tx_word_valid_i = 1'b0;
        chk("tx_busy_ready", {31'd0, bus.tx_word_ready_o}, 32'd0);
        chk("tx_busy_valid", {31'd0, bus.tx_valid_o}, 32'd1);
        wait_tx_idle("tx_idle");
    endtask

    always @(negedge clk) begin
        if (rstn_i && bus.rx_word_valid_o && bus.rx_word_ready_i) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %08h expected none",
                         bus.rx_word_o);
            end else begin
                chk("rx_word", bus.rx_word_o, rx_q.pop_front());
            end
        end
    end

    // uart_tx model: done pulse 5 cycles into each byte
    initial begin
        forever begin
            @(posedge clk);
            #1;
            prev_done = resp_done;
            resp_done = 1'b0;
            if (resp_en && prev_done && tx_q.size() != 0) begin
                chk("tx_no_bubble", {31'd0, bus.tx_valid_o}, 32'd1);
            end
            if (resp_en && bus.tx_valid_o) begin
                resp_dly++;
                if (resp_dly == 5) begin
                    resp_dly = 0;
                    tx_dones++;
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %02h expected none",
                                 bus.tx_byte_o);
                    end else begin
                        chk("tx_byte", {24'd0, bus.tx_byte_o},
                            {24'd0, tx_q.pop_front()});
                    end
                    resp_done = 1'b1;
                end
            end else begin
                resp_dly = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        rx_vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        rx_vecs[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        rx_vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
        rx_vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};
        rx_vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'h80000000};
        tx_vecs[0] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        tx_vecs[1] = '{32'h01234567, 8'h67, 8'h45, 8'h23, 8'h01};
        tx_vecs[2] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};

        bus.flush_i         = 1'b0;
        bus.rx_byte_i       = 8'h00;
        bus.rx_valid_i      = 1'b0;
        bus.rx_word_ready_i = 1'b0;
        bus.tx_word_i       = 32'h0;
        bus.tx_word_valid_i = 1'b0;

        repeat (3) tick();
        chk("rst_rx_valid", {31'd0, bus.rx_word_valid_o}, 32'd0);
        chk("rst_rx_word", bus.rx_word_o, 32'd0);
        chk("rst_tx_ready", {31'd0, bus.tx_word_ready_o}, 32'd1);
        chk("rst_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
        chk("rst_tx_byte", {24'd0, bus.tx_byte_o}, 32'd0);
        chk("rst_timeout", {31'd0, bus.rx_timeout_o}, 32'd0);
        chk("rst_overrun", {31'd0, bus.rx_overrun_o}, 32'd0);
        rstn_i = 1'b1;
        tick();

        // Basic word: valid exactly one cycle after the 4th byte
        bus.rx_word_ready_i = 1'b1;
        rx_q.push_back(32'h12345678);
        rx_byte(8'h78);
        rx_byte(8'h56);
        rx_byte(8'h34);
        chk("rx1_not_early", {31'd0, bus.rx_word_valid_o}, 32'd0);
        rx_byte(8'h12);
        chk("rx1_valid", {31'd0, bus.rx_word_valid_o}, 32'd1);
        chk("rx1_word", bus.rx_word_o, 32'h12345678);
        tick();
        chk("rx1_valid_drop", {31'd0, bus.rx_word_valid_o}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            rx_word(rx_vecs[i]);
        end
        tick();

        resp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0 = tx_dones;
            tx_send(tx_vecs[i]);
            chk("tx_done_count", tx_dones - d0, 32'd4);
        end

        // done while idle must not start anything
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        chk("idle_done_ready", {31'd0, bus.tx_word_ready_o}, 32'd1);
        chk("idle_done_valid", {31'd0, bus.tx_valid_o}, 32'd0);

        // RX and TX together
        fork
            tx_send(tx_vecs[0]);
            rx_word(rx_vecs[3]);
        join

        // Byte lands in the cycle the timer would expire
        rx_q.push_back(32'hA4A3A2A1);
        rx_byte(8'hA1);
        repeat (TO - 1) tick();
        rx_byte(8'hA2);
        rx_byte(8'hA3);
        rx_byte(8'hA4);
        tick();
        chk("race_no_timeout", {31'd0, bus.rx_timeout_o}, 32'd0);

        rx_byte(8'hB1);
        rx_byte(8'hB2);
        repeat (TO - 1) tick();
        chk("to_not_yet", {31'd0, bus.rx_timeout_o}, 32'd0);
        tick();
        chk("to_set", {31'd0, bus.rx_timeout_o}, 32'd1);
        rx_word(rx_vecs[1]);
        tick();
        chk("to_sticky", {31'd0, bus.rx_timeout_o}, 32'd1);

        // Overrun: consumer stalled across two words
        bus.rx_word_ready_i = 1'b0;
        rx_q.push_back(32'h11223344);
        rx_byte(8'h44);
        rx_byte(8'h33);
        rx_byte(8'h22);
        rx_byte(8'h11);
        rx_byte(8'h88);
        rx_byte(8'h77);
        rx_byte(8'h66);
        rx_byte(8'h55);
        tick();
        chk("ovr_valid", {31'd0, bus.rx_word_valid_o}, 32'd1);
        chk("ovr_word", bus.rx_word_o, 32'h11223344);
        chk("ovr_flag", {31'd0, bus.rx_overrun_o}, 32'd1);
        bus.rx_word_ready_i = 1'b1;
        tick();
        chk("ovr_drained", {31'd0, bus.rx_word_valid_o}, 32'd0);

        // Flush during TX byte 2 and RX byte 3 with a word pending
        bus.rx_word_ready_i = 1'b0;
        rx_byte(8'hAA);
        rx_byte(8'hBB);
        rx_byte(8'hCC);
        rx_byte(8'hDD);
        tx_q.push_back(8'hEF);
        tx_q.push_back(8'hBE);
        tx_q.push_back(8'hAD);
        tx_q.push_back(8'hDE);
        bus.tx_word_i       = 32'hDEADBEEF;
        bus.tx_word_valid_i = 1'b1;
        tick();
        bus.tx_word_valid_i = 1'b0;
        rx_byte(8'h11);
        rx_byte(8'h22);
        n = 0;
        while (tx_dones == d0 + 8 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("fl_pre_valid", {31'd0, bus.tx_valid_o}, 32'd1);
        bus.flush_i    = 1'b1;
        bus.rx_byte_i  = 8'h33;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        chk("fl_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
        chk("fl_tx_ready", {31'd0, bus.tx_word_ready_o}, 32'd1);
        chk("fl_rx_valid", {31'd0, bus.rx_word_valid_o}, 32'd0);
        chk("fl_timeout", {31'd0, bus.rx_timeout_o}, 32'd0);
        chk("fl_overrun", {31'd0, bus.rx_overrun_o}, 32'd0);
        tx_q.delete();
        bus.rx_word_ready_i = 1'b1;
        rx_q.push_back(32'hF00FA55A);
        rx_byte(8'h5A);
        rx_byte(8'hA5);
        rx_byte(8'h0F);
        rx_byte(8'hF0);
        tick();

        // 4th byte in the same cycle the old word is accepted
        bus.rx_word_ready_i = 1'b0;
        rx_q.push_back(32'hCAFEF00D);
        rx_byte(8'h0D);
        rx_byte(8'hF0);
        rx_byte(8'hFE);
        rx_byte(8'hCA);
        rx_byte(8'hEF);
        rx_byte(8'hBE);
        rx_byte(8'hAD);
        rx_q.push_back(32'h0BADBEEF);
        bus.rx_word_ready_i = 1'b1;
        rx_byte(8'h0B);
        bus.rx_word_ready_i = 1'b0;
        chk("acc_valid", {31'd0, bus.rx_word_valid_o}, 32'd1);
        chk("acc_word", bus.rx_word_o, 32'h0BADBEEF);
        chk("acc_no_ovr", {31'd0, bus.rx_overrun_o}, 32'd0);
        bus.rx_word_ready_i = 1'b1;
        tick();

        // Async reset drops a partial word silently
        rx_byte(8'hE1);
        rx_byte(8'hE2);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_rx_valid", {31'd0, bus.rx_word_valid_o}, 32'd0);
        chk("arst_tx_ready", {31'd0, bus.tx_word_ready_o}, 32'd1);
        tick();
        rstn_i = 1'b1;
        tick();
        rx_q.push_back(32'h40302010);
        rx_byte(8'h10);
        rx_byte(8'h20);
        rx_byte(8'h30);
        rx_byte(8'h40);
        repeat (3) tick();
        chk("arst_no_timeout", {31'd0, bus.rx_timeout_o}, 32'd0);

        repeat (5) tick();
        chk("rx_q_empty", rx_q.size(), 32'd0);
        chk("tx_q_empty", tx_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
